str_acq: RTL and testbench
==========================

STR_ACQ -- requirements
Module: str_acq

Interface
REQ-001 The block SHALL have parameter DN, default 1, meaning number of data lanes in the stream interfaces.
REQ-002 The block SHALL have parameter CW, default 32, meaning the width of the pre-trigger and post-trigger counters.
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; both stream interfaces run on it.
REQ-004 The block SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports ctl_rst, ctl_acq, ctl_stp and ctl_trg, each input, 1 bit: soft reset, start acquisition, stop acquisition and trigger pulse respectively.
REQ-006 The block SHALL have ports cfg_pre and cfg_pst, each input, CW bits: pre-trigger and post-trigger sample counts.
REQ-007 The block SHALL have ports sts_acq and sts_trg, each output, 1 bit: acquisition active and trigger accepted.
REQ-008 The block SHALL have ports sts_pre and sts_pst, each output, CW bits: pre-trigger and post-trigger transfer counts.
REQ-009 The block SHALL have port sts_tts, output, 64 bits: trigger timestamp.
REQ-010 The block SHALL have sti, an axi4_stream_if.d input stream, and sto, an axi4_stream_if.s output stream; the ACLK/ARESETn signals of both interfaces are unused.

Function
REQ-011 The state machine SHALL have exactly four states: IDLE, PRE, ARM and POST.
REQ-012 IDLE: sti.TREADY=1, input transfers are discarded, and no output is produced.
REQ-013 ctl_acq in IDLE SHALL go to PRE if cfg_pre!=0, otherwise to ARM; it also clears sts_pre and sts_pst. ctl_acq in any other state SHALL be ignored.
REQ-014 PRE: each input transfer increments sts_pre; when sts_pre==cfg_pre-1 and a transfer occurs, the state SHALL go to ARM.
REQ-015 ARM: transfers SHALL keep incrementing sts_pre, saturating at 2^CW-1; ctl_trg=1 SHALL go to POST and capture the timestamp. ctl_trg SHALL be ignored in every state other than ARM.
REQ-016 A transfer in the trigger-acceptance cycle SHALL count as a pre-trigger sample.
REQ-017 POST: each transfer increments sts_pst; the transfer that makes sts_pst equal max(cfg_pst,1) SHALL carry TLAST=1, and the state then goes to IDLE.
REQ-018 In PRE, ARM and POST, each accepted input sample SHALL be registered into sto with latency exactly 1 cycle; TDATA and TKEEP pass through unchanged.
REQ-019 In PRE, ARM and POST, sto.TLAST SHALL be 1 only on the final POST sample; the input TLAST is ignored.
REQ-020 Handshake: sti.TREADY = sto.TREADY | ~sto.TVALID while not IDLE; sto.TVALID SHALL hold its data stable until sto.TREADY.
REQ-021 ctl_stp SHALL force IDLE; a sample already in the output register is still delivered, with TLAST=0.
REQ-022 ctl_rst SHALL force IDLE, clear sto.TVALID (dropping any pending sample), clear sts_pre, sts_pst and sts_tts, and clear the timestamp counter.
REQ-023 Simultaneous control inputs SHALL resolve with priority ctl_rst > ctl_stp > ctl_acq > ctl_trg.
REQ-024 Status outputs: sts_acq = (state!=IDLE) and sts_trg = (state==POST); both are registered state decodes.
REQ-025 cfg_pre and cfg_pst SHALL be sampled continuously; changing them mid-acquisition takes effect on the next comparison.

Reset
REQ-026 On ARESET=1, on the ACLK edge, the block SHALL set state=IDLE, sto.TVALID=0, sto.TLAST=0, sts_acq=0, sts_trg=0, sts_pre=0, sts_pst=0 and sts_tts=0.
REQ-027 sto.TDATA and sto.TKEEP SHALL have no reset.

Configuration
REQ-028 With STR_ACQ_TIMESTAMP_EN defined: a 64-bit free-running counter SHALL increment every cycle, wrap from 2^64-1 to 0, and be captured into sts_tts on trigger acceptance.
REQ-029 Without STR_ACQ_TIMESTAMP_EN: the counter SHALL be absent and sts_tts SHALL be tied to 0.

Structure
REQ-030 The state enum (IDLE, PRE, ARM, POST) and the timestamp width constant (64) SHALL be in shared package str_acq_pkg.
REQ-031 A single sub-module, str_acq_cnt (a saturating/compare counter), SHALL be instantiated for both the pre-trigger and post-trigger counts.

Verification
REQ-032 The bench SHALL cover: cfg_pre=4, cfg_pst=3, continuous input 0,1,2..., ctl_trg at input 10 -> output 0..13, TLAST on 13, sts_pre=11, sts_pst=3, then IDLE.
REQ-033 The bench SHALL cover: ctl_trg in PRE (after 2 of 4 samples), then again in ARM -> the first pulse is ignored and POST starts only at the second pulse.
REQ-034 The bench SHALL cover: cfg_pre=0, cfg_pst=0, ctl_acq, ctl_trg on the next cycle -> ARM entered immediately, exactly 1 POST sample, with TLAST=1.
REQ-035 The bench SHALL cover: sto.TREADY toggling 50% in POST with cfg_pst=5 -> no loss or duplication, exactly 5 post samples, TLAST on the 5th.
REQ-036 The bench SHALL cover: ctl_rst and ctl_trg in the same cycle in ARM with a pending output -> IDLE, sto.TVALID=0 next cycle, sts_tts=0.
REQ-037 The bench SHALL cover, with STR_ACQ_TIMESTAMP_EN: trigger accepted 100 cycles after ARESET release -> sts_tts=100 (exactly 99 or 100 per the counter's first increment, fixed in the testplan).

Source files
------------

// File: rtl/str_acq_pkg.sv
// Shared types and constants for the stream acquisition block.
package str_acq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ARM,
    POST
  } state_t;

  localparam int unsigned TS_W = 64;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; modport s drives a stream, modport d receives one.
interface axi4_stream_if #(
  parameter int DN = 1
) (
  input logic ACLK,
  input logic ARESETn
);

  logic [8*DN-1:0] TDATA;
  logic [DN-1:0]   TKEEP;
  logic            TLAST;
  logic            TVALID;
  logic            TREADY;

  modport s (input ACLK, ARESETn, output TDATA, TKEEP, TLAST, TVALID, input TREADY);
  modport d (input ACLK, ARESETn, input TDATA, TKEEP, TLAST, TVALID, output TREADY);

endinterface

// File: rtl/str_acq_cnt.sv
// Saturating up-counter; hit flags that the next increment reaches lim.
module str_acq_cnt #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] lim,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  logic [CW-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
  end

  assign hit = (cnt_inc == lim);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/str_acq.sv
// Triggered stream acquisition: pre-trigger and post-trigger capture into a registered output.
// Optional trigger timestamp counter enabled by STR_ACQ_TIMESTAMP_EN.
module str_acq
  import str_acq_pkg::*;
#(
  parameter int DN = 1,
  parameter int CW = 32
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            ctl_rst,
  input  logic            ctl_acq,
  input  logic            ctl_stp,
  input  logic            ctl_trg,
  input  logic [CW-1:0]   cfg_pre,
  input  logic [CW-1:0]   cfg_pst,
  output logic            sts_acq,
  output logic            sts_trg,
  output logic [CW-1:0]   sts_pre,
  output logic [CW-1:0]   sts_pst,
  output logic [TS_W-1:0] sts_tts,
  axi4_stream_if.d        sti,
  axi4_stream_if.s        sto
);

  state_t          state, state_nxt;
  logic            in_rdy, in_xfer, load;
  logic            acq_start, out_last;
  logic            pre_hit, pst_hit;
  logic            cnt_clr, pre_inc, pst_inc;
  logic [CW-1:0]   pst_lim;
  logic            o_valid, o_last;
  logic [8*DN-1:0] o_data;
  logic [DN-1:0]   o_keep;

  assign in_rdy     = (state == IDLE) | sto.TREADY | ~o_valid;
  assign sti.TREADY = in_rdy;
  assign in_xfer    = sti.TVALID & in_rdy;
  assign load       = in_xfer & (state != IDLE);

  assign pst_lim = (cfg_pst == '0) ? CW'(1) : cfg_pst;
  assign cnt_clr = ctl_rst | acq_start;
  assign pre_inc = in_xfer & ~ctl_rst & ((state == PRE) | (state == ARM));
  assign pst_inc = in_xfer & ~ctl_rst & (state == POST);

  str_acq_cnt #(.CW(CW)) u_pre (
    .clk (ACLK),
    .rst (ARESET),
    .clr (cnt_clr),
    .inc (pre_inc),
    .lim (cfg_pre),
    .cnt (sts_pre),
    .hit (pre_hit)
  );

  str_acq_cnt #(.CW(CW)) u_pst (
    .clk (ACLK),
    .rst (ARESET),
    .clr (cnt_clr),
    .inc (pst_inc),
    .lim (pst_lim),
    .cnt (sts_pst),
    .hit (pst_hit)
  );

  always_comb begin
    state_nxt = state;
    acq_start = 1'b0;
    out_last  = 1'b0;
    if (ctl_rst || ctl_stp) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ctl_acq) begin
          acq_start = 1'b1;
          state_nxt = (cfg_pre != '0) ? PRE : ARM;
        end
        PRE:  if (in_xfer && pre_hit) state_nxt = ARM;
        ARM:  if (ctl_trg) state_nxt = POST;
        POST: if (in_xfer && pst_hit) begin
          out_last  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A sample accepted in the stop cycle is still forwarded, but never as a packet end.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      sts_acq <= 1'b0;
      sts_trg <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sts_acq <= (state_nxt != IDLE);
      sts_trg <= (state_nxt == POST);
      if (ctl_rst) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else if (load) begin
        o_valid <= 1'b1;
        o_last  <= out_last & ~ctl_stp;
      end else if (sto.TREADY) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (load) begin
      o_data <= sti.TDATA;
      o_keep <= sti.TKEEP;
    end
  end

  assign sto.TVALID = o_valid;
  assign sto.TLAST  = o_last;
  assign sto.TDATA  = o_data;
  assign sto.TKEEP  = o_keep;

`ifdef STR_ACQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic            trg_acc;

  assign trg_acc = (state == ARM) & ctl_trg & ~ctl_rst & ~ctl_stp;

  // The captured stamp is the value the counter takes on the acceptance edge.
  always_ff @(posedge ACLK) begin
    if (ARESET || ctl_rst) begin
      ts_cnt  <= '0;
      sts_tts <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (trg_acc) sts_tts <= ts_cnt + TS_W'(1);
    end
  end
`else
  assign sts_tts = '0;
`endif

endmodule

// File: tb/tb_str_acq.sv
// Directed scenarios with randomized stream traffic, checked against a transaction-level acquisition model.
module tb_str_acq;
  import str_acq_pkg::*;

  localparam int DN  = 1;
  localparam int CW  = 8;
  localparam int SAT = 255;
`ifdef STR_ACQ_TIMESTAMP_EN
  localparam longint unsigned TTS_100 = 100;
`else
  localparam longint unsigned TTS_100 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset, ctl_rst, ctl_acq, ctl_stp, ctl_trg;
  logic [CW-1:0]   cfg_pre, cfg_pst;
  logic            sts_acq, sts_trg;
  logic [CW-1:0]   sts_pre, sts_pst;
  logic [TS_W-1:0] sts_tts;

  axi4_stream_if #(.DN(DN)) sti_if (.ACLK(clk), .ARESETn(~areset));
  axi4_stream_if #(.DN(DN)) sto_if (.ACLK(clk), .ARESETn(~areset));

  str_acq #(.DN(DN), .CW(CW)) dut (
    .ACLK    (clk),
    .ARESET  (areset),
    .ctl_rst (ctl_rst),
    .ctl_acq (ctl_acq),
    .ctl_stp (ctl_stp),
    .ctl_trg (ctl_trg),
    .cfg_pre (cfg_pre),
    .cfg_pst (cfg_pst),
    .sts_acq (sts_acq),
    .sts_trg (sts_trg),
    .sts_pre (sts_pre),
    .sts_pst (sts_pst),
    .sts_tts (sts_tts),
    .sti     (sti_if),
    .sto     (sto_if)
  );

  typedef enum {M_IDLE, M_PRE, M_ARM, M_POST} mode_t;
  typedef struct {
    logic [8*DN-1:0] d;
    logic [DN-1:0]   k;
    logic            l;
  } smp_t;

  smp_t            m_q[$];
  mode_t           m_mode = M_IDLE;
  int unsigned     m_pre = 0, m_pst = 0;
  longint unsigned m_ts = 0, m_tts = 0;
  int              n_assert = 0, n_fail = 0;
  int unsigned     vpct = 0, rpct = 100;
  bit              seq = 1'b0;
  logic [8*DN-1:0] seq_nx = '0;
  int              out_cnt = 0, out_lasts = 0;
  logic [8*DN-1:0] out_last_d = '0;
  bit              prev_stall = 1'b0;
  smp_t            prev_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, then update the source.
  task automatic step();
    bit          xin, xout, lst;
    smp_t        s;
    mode_t       nxt;
    int unsigned plim;
    sto_if.TREADY = ($urandom_range(99) < rpct);
    #1;
    check("sts_acq", 64'(sts_acq), 64'(m_mode != M_IDLE));
    check("sts_trg", 64'(sts_trg), 64'(m_mode == M_POST));
    check("sts_pre", 64'(sts_pre), 64'(m_pre));
    check("sts_pst", 64'(sts_pst), 64'(m_pst));
    check("sts_tts", sts_tts, m_tts);
    check("tvalid", 64'(sto_if.TVALID), 64'(m_q.size() != 0));
    if (m_mode == M_IDLE) check("idle_tready", 64'(sti_if.TREADY), 64'd1);
    if (prev_stall)
      check("hold", 64'({sto_if.TDATA, sto_if.TKEEP, sto_if.TLAST}), 64'({prev_s.d, prev_s.k, prev_s.l}));
    xout = sto_if.TVALID && sto_if.TREADY;
    if (xout && m_q.size() != 0) begin
      s = m_q.pop_front();
      check("tdata", 64'(sto_if.TDATA), 64'(s.d));
      check("tkeep", 64'(sto_if.TKEEP), 64'(s.k));
      check("tlast", 64'(sto_if.TLAST), 64'(s.l));
      out_cnt++;
      if (sto_if.TLAST) begin
        out_lasts++;
        out_last_d = sto_if.TDATA;
      end
    end
    prev_stall = sto_if.TVALID && !sto_if.TREADY;
    prev_s = '{sto_if.TDATA, sto_if.TKEEP, sto_if.TLAST};
    xin = sti_if.TVALID && sti_if.TREADY;

    if (areset || ctl_rst) begin
      m_mode = M_IDLE;
      m_pre = 0;
      m_pst = 0;
      m_ts = 0;
      m_tts = 0;
      m_q.delete();
      prev_stall = 1'b0;
    end else begin
      m_ts++;
      nxt = m_mode;
      lst = 1'b0;
      plim = (cfg_pst == 0) ? 1 : int'(cfg_pst);
      if (xin && m_mode != M_IDLE) begin
        if (m_mode == M_PRE) begin
          m_pre++;
          if (m_pre == cfg_pre) nxt = M_ARM;
        end else if (m_mode == M_ARM) begin
          if (m_pre < SAT) m_pre++;
        end else begin
          m_pst++;
          if (m_pst == plim) begin
            lst = 1'b1;
            nxt = M_IDLE;
          end
        end
        m_q.push_back('{sti_if.TDATA, sti_if.TKEEP, lst && !ctl_stp});
      end
      if (m_mode == M_ARM && ctl_trg && !ctl_stp) begin
        nxt = M_POST;
`ifdef STR_ACQ_TIMESTAMP_EN
        m_tts = m_ts;
`endif
      end
      if (ctl_stp) nxt = M_IDLE;
      else if (m_mode == M_IDLE && ctl_acq) begin
        m_pre = 0;
        m_pst = 0;
        nxt = (cfg_pre != 0) ? M_PRE : M_ARM;
      end
      m_mode = nxt;
    end

    @(posedge clk);
    @(negedge clk);
    ctl_rst = 1'b0;
    ctl_acq = 1'b0;
    ctl_stp = 1'b0;
    ctl_trg = 1'b0;
    if (!sti_if.TVALID || xin) begin
      sti_if.TVALID = ($urandom_range(99) < vpct);
      sti_if.TDATA  = seq ? seq_nx : (8*DN)'($urandom);
      sti_if.TKEEP  = DN'($urandom);
      sti_if.TLAST  = 1'($urandom);
      if (sti_if.TVALID && seq) seq_nx++;
    end
  endtask

  task automatic start_acq(input int unsigned pre, input int unsigned pst,
                           input int unsigned v, input int unsigned r, input bit sq);
    cfg_pre = CW'(pre);
    cfg_pst = CW'(pst);
    vpct = v;
    rpct = r;
    seq = sq;
    seq_nx = '0;
    out_cnt = 0;
    out_lasts = 0;
    sti_if.TVALID = 1'b0;
    ctl_acq = 1'b1;
    step();
  endtask

  task automatic run_until_idle();
    int i = 0;
    while (i < 400 && (m_mode != M_IDLE || m_q.size() != 0)) begin
      step();
      i++;
    end
    check("idle_timeout", 64'(m_mode != M_IDLE || m_q.size() != 0), 64'd0);
  endtask

  task automatic wait_offer(input int unsigned val);
    int i = 0;
    while (i < 40 && !(sti_if.TVALID && sti_if.TDATA == (8*DN)'(val))) begin
      step();
      i++;
    end
    check("offer_timeout", 64'(i >= 40), 64'd0);
  endtask

  initial begin
    areset = 1'b1;
    ctl_rst = 1'b0; ctl_acq = 1'b0; ctl_stp = 1'b0; ctl_trg = 1'b0;
    cfg_pre = '0; cfg_pst = '0;
    sti_if.TVALID = 1'b0; sti_if.TDATA = '0; sti_if.TKEEP = '0; sti_if.TLAST = 1'b0;
    sto_if.TREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step();
    areset = 1'b0;
    check("rst_tvalid", 64'(sto_if.TVALID), 64'd0);
    check("rst_tlast", 64'(sto_if.TLAST), 64'd0);
    check("rst_acq", 64'(sts_acq), 64'd0);
    check("rst_tts", sts_tts, 64'd0);

    // Trigger accepted on the 100th edge after reset release
    start_acq(0, 2, 70, 100, 1'b0);
    repeat (98) step();
    ctl_trg = 1'b1;
    step();
    check("tts_100", sts_tts, TTS_100);
    run_until_idle();

    // Continuous 0,1,2..; trigger with input 10
    start_acq(4, 3, 100, 100, 1'b1);
    wait_offer(10);
    ctl_trg = 1'b1;
    step();
    run_until_idle();
    check("s1_out_cnt", 64'(out_cnt), 64'd14);
    check("s1_last_d", 64'(out_last_d), 64'd13);
    check("s1_lasts", 64'(out_lasts), 64'd1);
    check("s1_pre", 64'(sts_pre), 64'd11);
    check("s1_pst", 64'(sts_pst), 64'd3);
    check("s1_idle", 64'(sts_acq), 64'd0);

    // Trigger in PRE is ignored; the one in ARM starts POST
    start_acq(4, 2, 100, 100, 1'b1);
    wait_offer(2);
    ctl_trg = 1'b1;
    step();
    check("s2_trg_ign", 64'(sts_trg), 64'd0);
    check("s2_still_acq", 64'(sts_acq), 64'd1);
    wait_offer(6);
    ctl_trg = 1'b1;
    step();
    check("s2_trg_acc", 64'(sts_trg), 64'd1);
    check("s2_pre", 64'(sts_pre), 64'd7);
    run_until_idle();
    check("s2_out_cnt", 64'(out_cnt), 64'd9);
    check("s2_last_d", 64'(out_last_d), 64'd8);

    // Zero pre and post counts: ARM at once, one post sample carrying TLAST
    start_acq(0, 0, 100, 100, 1'b1);
    check("s3_arm", 64'(sts_acq && !sts_trg), 64'd1);
    ctl_trg = 1'b1;
    step();
    run_until_idle();
    check("s3_out_cnt", 64'(out_cnt), 64'd2);
    check("s3_lasts", 64'(out_lasts), 64'd1);
    check("s3_last_d", 64'(out_last_d), 64'd1);
    check("s3_pre", 64'(sts_pre), 64'd1);
    check("s3_pst", 64'(sts_pst), 64'd1);

    // Backpressure during POST
    start_acq(3, 5, 70, 50, 1'b0);
    repeat (8) step();
    while (m_mode == M_PRE) step();
    ctl_trg = 1'b1;
    step();
    run_until_idle();
    check("s4_pst", 64'(sts_pst), 64'd5);
    check("s4_out_cnt", 64'(out_cnt), 64'(sts_pre) + 64'd5);
    check("s4_lasts", 64'(out_lasts), 64'd1);

    // Soft reset beats trigger while an output is pending
    start_acq(0, 3, 100, 0, 1'b0);
    step();
    step();
    check("s5_pending", 64'(sto_if.TVALID), 64'd1);
    ctl_rst = 1'b1;
    ctl_trg = 1'b1;
    step();
    check("s5_tvalid", 64'(sto_if.TVALID), 64'd0);
    check("s5_tts", sts_tts, 64'd0);
    check("s5_acq", 64'(sts_acq), 64'd0);
    check("s5_trg", 64'(sts_trg), 64'd0);
    rpct = 100;
    run_until_idle();

    // Pre counter saturation, then stop with a pending sample
    start_acq(2, 1, 100, 100, 1'b0);
    repeat (300) step();
    check("s6_sat", 64'(sts_pre), 64'(SAT));
    rpct = 0;
    step();
    ctl_stp = 1'b1;
    step();
    check("s6_stp_valid", 64'(sto_if.TVALID), 64'd1);
    check("s6_stp_last", 64'(sto_if.TLAST), 64'd0);
    check("s6_stp_idle", 64'(sts_acq), 64'd0);
    rpct = 100;
    run_until_idle();
    check("s6_no_last", 64'(out_lasts), 64'd0);

    // Randomized configurations and traffic
    for (int it = 0; it < 6; it++) begin
      start_acq($urandom_range(5, 0), $urandom_range(4, 0), $urandom_range(100, 50),
                $urandom_range(100, 40), 1'b0);
      repeat ($urandom_range(12, 0)) step();
      for (int k = 0; k < 40 && (m_mode == M_PRE || m_mode == M_ARM); k++) begin
        ctl_trg = 1'b1;
        step();
      end
      if (it % 2 == 1) begin
        repeat ($urandom_range(3, 0)) step();
        if (m_mode != M_IDLE) ctl_stp = 1'b1;
        step();
      end
      run_until_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
